// File: rtl/regfile_access_ctrl.sv
// Register-file write/read-port controller: zero-fill after reset, core-priority
// write arbitration with a debug starvation guard, and registered debug reads.
module regfile_access_ctrl #(
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = $clog2(NUM_REGS),
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DBG_MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_wr_valid,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_wr_ready,
  input  logic              dbg_req_valid,
  input  logic              dbg_req_we,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_req_ready,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              rf_RegWrite,
  output logic [ADDR_W-1:0] rf_WriteRegister,
  output logic [DATA_W-1:0] rf_WriteData,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              init_done
);

  localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  MAX_WAIT = CNT_W'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DBG_RD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                init_done_q, init_done_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic force_dbg;
  logic core_grant;
  logic dbg_grant;

  assign force_dbg = (state_q == S_IDLE) && dbg_req_valid && (wait_cnt_q == MAX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_idx_q   <= ADDR_W'(1);
      wait_cnt_q  <= '0;
      init_done_q <= (CLEAR_ON_RESET == 0);
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wait_cnt_d  = wait_cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rd_addr_d   = rd_addr_q;
    case (state_q)
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (dbg_grant && !dbg_req_we) begin
          rd_addr_d = dbg_req_addr;
          state_d   = S_DBG_RD;
        end
      end
      S_DBG_RD: begin
        // Bypass a same-cycle core write so the read never returns stale data.
        if (rd_addr_q == '0)
          rsp_rdata_d = '0;
        else if (core_grant && (core_wr_addr == rd_addr_q))
          rsp_rdata_d = core_wr_data;
        else
          rsp_rdata_d = rf_rd_data;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!dbg_req_valid || dbg_grant)
      wait_cnt_d = '0;
    else if ((state_q == S_IDLE) && (wait_cnt_q != MAX_WAIT))
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_comb begin
    core_wr_ready    = 1'b0;
    dbg_req_ready    = 1'b0;
    rf_RegWrite      = 1'b0;
    rf_WriteRegister = '0;
    rf_WriteData     = '0;
    rf_rd_addr       = '0;
    core_grant       = 1'b0;
    dbg_grant        = 1'b0;
    if (state_q == S_CLEAR) begin
      rf_RegWrite      = 1'b1;
      rf_WriteRegister = clr_idx_q;
    end else begin
      core_wr_ready = !force_dbg;
      dbg_req_ready = (state_q == S_IDLE) && (force_dbg || !core_wr_valid);
      if (state_q == S_DBG_RD)
        rf_rd_addr = rd_addr_q;
      core_grant = core_wr_valid && core_wr_ready;
      dbg_grant  = dbg_req_valid && dbg_req_ready;
      // x0 writes complete the handshake but never reach the register file.
      if (core_grant) begin
        rf_RegWrite      = (core_wr_addr != '0);
        rf_WriteRegister = core_wr_addr;
        rf_WriteData     = core_wr_data;
      end else if (dbg_grant && dbg_req_we) begin
        rf_RegWrite      = (dbg_req_addr != '0);
        rf_WriteRegister = dbg_req_addr;
        rf_WriteData     = dbg_req_wdata;
      end
    end
  end

  assign init_done     = init_done_q;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 32x32 register file
// attached to its write port and spare read port.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_wr_valid;
  logic [4:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        core_wr_ready;
  logic        dbg_req_valid;
  logic        dbg_req_we;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_req_ready;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_rdata;
  logic        rf_RegWrite;
  logic [4:0]  rf_WriteRegister;
  logic [31:0] rf_WriteData;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .core_wr_valid(core_wr_valid), .core_wr_addr(core_wr_addr),
    .core_wr_data(core_wr_data), .core_wr_ready(core_wr_ready),
    .dbg_req_valid(dbg_req_valid), .dbg_req_we(dbg_req_we),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_rdata(dbg_rsp_rdata), .rf_RegWrite(rf_RegWrite),
    .rf_WriteRegister(rf_WriteRegister), .rf_WriteData(rf_WriteData),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .init_done(init_done)
  );

  // x0 holds a non-zero pattern so the controller's own x0 handling is observable.
  always @(posedge clk) if (rf_RegWrite) mem[rf_WriteRegister] <= rf_WriteData;
  assign rf_rd_data = mem[rf_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_wr_valid = 1'b0; core_wr_addr = '0; core_wr_data = '0;
    dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
  endtask

  task automatic run_clear(input string tag);
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk({tag, "_we"}, 32'(rf_RegWrite), 32'd1);
      chk({tag, "_addr"}, 32'(rf_WriteRegister), 32'(i));
      chk({tag, "_data"}, rf_WriteData, 32'd0);
      chk({tag, "_rdy"}, 32'({core_wr_ready, dbg_req_ready}), 32'd0);
      chk({tag, "_done"}, 32'(init_done), 32'd0);
      step();
    end
    #1;
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    chk({tag, "_core_rdy"}, 32'(core_wr_ready), 32'd1);
    chk({tag, "_idle_we"}, 32'(rf_RegWrite), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[0] = 32'hBAD0BAD0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    core_wr_valid = 1'b1; core_wr_addr = 5'd3; core_wr_data = 32'h5555;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd4;
    #1;
    chk("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", dbg_rsp_rdata, 32'd0);
    chk("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
    idle_inputs();
    run_clear("clr");
    for (int i = 1; i < 32; i++) chk("clr_mem", mem[i], 32'd0);

    // Core and debug write collide: core first, debug next cycle.
    core_wr_valid = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'hABCDE123;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd6; dbg_req_wdata = 32'h11;
    #1;
    chk("arb_core_rdy", 32'(core_wr_ready), 32'd1);
    chk("arb_dbg_rdy", 32'(dbg_req_ready), 32'd0);
    chk("arb_core_wreg", 32'(rf_WriteRegister), 32'd5);
    chk("arb_core_wdata", rf_WriteData, 32'hABCDE123);
    step();
    core_wr_valid = 1'b0;
    #1;
    chk("arb_dbg_rdy2", 32'(dbg_req_ready), 32'd1);
    chk("arb_dbg_we", 32'(rf_RegWrite), 32'd1);
    chk("arb_dbg_wreg", 32'(rf_WriteRegister), 32'd6);
    chk("arb_dbg_wdata", rf_WriteData, 32'h11);
    step();
    idle_inputs();

    // Debug read of x5, then x0.
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd5;
    #1;
    chk("rd5_rdy", 32'(dbg_req_ready), 32'd1);
    chk("rd5_no_write", 32'(rf_RegWrite), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("rd5_rd_addr", 32'(rf_rd_addr), 32'd5);
    chk("rd5_early_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rd5_busy_rdy", 32'(dbg_req_ready), 32'd0);
    step();
    chk("rd5_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("rd5_rdata", dbg_rsp_rdata, 32'hABCDE123);
    chk("rd5_rd_addr_idle", 32'(rf_rd_addr), 32'd0);
    step();
    chk("rd5_pulse_end", 32'(dbg_rsp_valid), 32'd0);
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd0;
    step();
    idle_inputs();
    step();
    chk("rd0_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("rd0_rdata", dbg_rsp_rdata, 32'd0);
    step();

    // Starvation guard: eight blocked cycles, forced grant on the ninth.
    core_wr_valid = 1'b1; core_wr_addr = 5'd9;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 5'd10; dbg_req_wdata = 32'h77;
    for (int i = 0; i < 8; i++) begin
      core_wr_data = 32'h900 + 32'(i);
      #1;
      chk("starve_core_rdy", 32'(core_wr_ready), 32'd1);
      chk("starve_dbg_blocked", 32'(dbg_req_ready), 32'd0);
      step();
    end
    #1;
    chk("force_core_rdy", 32'(core_wr_ready), 32'd0);
    chk("force_dbg_rdy", 32'(dbg_req_ready), 32'd1);
    chk("force_wreg", 32'(rf_WriteRegister), 32'd10);
    chk("force_wdata", rf_WriteData, 32'h77);
    step();
    dbg_req_addr = 5'd11;
    #1;
    chk("cnt_cleared_dbg_rdy", 32'(dbg_req_ready), 32'd0);
    chk("cnt_cleared_core_rdy", 32'(core_wr_ready), 32'd1);
    step();
    idle_inputs();
    chk("starve_mem9", mem[9], 32'h907);
    chk("starve_mem10", mem[10], 32'h77);

    // Core write to x0 handshakes without touching the register file.
    core_wr_valid = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'hFFFFFFFF;
    #1;
    chk("x0_core_rdy", 32'(core_wr_ready), 32'd1);
    chk("x0_no_write", 32'(rf_RegWrite), 32'd0);
    step();
    idle_inputs();

    // Same-cycle core write bypasses into the debug read of x7.
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd7;
    step();
    idle_inputs();
    core_wr_valid = 1'b1; core_wr_addr = 5'd7; core_wr_data = 32'h42;
    #1;
    chk("byp_core_rdy", 32'(core_wr_ready), 32'd1);
    chk("byp_we", 32'(rf_RegWrite), 32'd1);
    step();
    idle_inputs();
    chk("byp_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("byp_rdata", dbg_rsp_rdata, 32'h42);
    step();

    // Reset at clear index 10 restarts the clear from x1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("mid_clr_idx", 32'(rf_WriteRegister), 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_clr_restart", 32'(rf_WriteRegister), 32'd1);
    chk("mid_clr_done", 32'(init_done), 32'd0);
    run_clear("reclr");

    // Reset while a debug read is in flight drops its response.
    dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 5'd5;
    step();
    idle_inputs();
    #1;
    chk("rstrd_in_rd", 32'(rf_rd_addr), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstrd_no_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("rstrd_clear_addr", 32'(rf_WriteRegister), 32'd1);
    chk("rstrd_done", 32'(init_done), 32'd0);
    step();
    chk("rstrd_no_valid2", 32'(dbg_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Owns the write port and a dedicated read port of the 32x32 RegisterFile. After reset it clears x1..x31 through the write port. It then arbitrates register writes between the core writeback stage and a debug/host port. Core has fixed priority, with a starvation guard for debug. Debug reads are served through the spare read port with a one-cycle-registered response.

Parameters:
NUM_REGS, 32, number of architectural registers (x0 hardwired zero)
ADDR_W, 5, register index width; $clog2(NUM_REGS)
DATA_W, 32, register data width
CLEAR_ON_RESET, 1, 1 = run zero-fill sequence after reset; 0 = go straight to IDLE
DBG_MAX_WAIT, 8, consecutive blocked debug-request cycles before a forced debug grant

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
core_wr_valid  in  1  core writeback request
core_wr_addr  in  ADDR_W  core destination register
core_wr_data  in  DATA_W  core writeback data
core_wr_ready  out  1  core write accepted this cycle when valid&&ready
dbg_req_valid  in  1  debug request
dbg_req_we  in  1  1 = write, 0 = read
dbg_req_addr  in  ADDR_W  debug register index
dbg_req_wdata  in  DATA_W  debug write data
dbg_req_ready  out  1  debug request accepted when valid&&ready
dbg_rsp_valid  out  1  one-cycle pulse, read data valid
dbg_rsp_rdata  out  DATA_W  debug read data
rf_RegWrite  out  1  to RegisterFile.RegWrite
rf_WriteRegister  out  ADDR_W  to RegisterFile.WriteRegister
rf_WriteData  out  DATA_W  to RegisterFile.WriteData
rf_rd_addr  out  ADDR_W  spare read-port address
rf_rd_data  in  DATA_W  spare read-port data, combinational read
init_done  out  1  high once clear is complete; stays high until rst

Behaviour:
- FSM states: CLEAR, IDLE, DBG_RD.
- Reset (rst=1 at an edge) forces the following: state = CLEAR if CLEAR_ON_RESET, else IDLE. clr_idx = 1, wait_cnt = 0, init_done = 0 (1 if !CLEAR_ON_RESET), dbg_rsp_valid = 0, dbg_rsp_rdata = 0, latched read addr = 0.
- Reset mid-operation: a pending debug read is dropped with no response, and the clear sequence restarts from x1.

CLEAR state:
- rf_RegWrite = 1, rf_WriteRegister = clr_idx, rf_WriteData = 0.
- clr_idx increments each cycle. When clr_idx == NUM_REGS-1 the next state is IDLE and init_done <= 1.
- Duration: exactly NUM_REGS-1 = 31 cycles.
- core_wr_ready = 0 and dbg_req_ready = 0 throughout.

IDLE / DBG_RD write arbitration (rf_* outputs are combinational from the grant):
- force_dbg = (state == IDLE) && dbg_req_valid && (wait_cnt == DBG_MAX_WAIT).
- core_wr_ready = !force_dbg in IDLE and in DBG_RD.
- dbg_req_ready = (state == IDLE) && (force_dbg || !core_wr_valid).
- Core grant: rf_RegWrite = (core_wr_addr != 0), address and data from core.
- Debug write grant: rf_RegWrite = (dbg_req_addr != 0), address and data from dbg.
- Writes to x0 are accepted (handshake completes) but never drive rf_RegWrite.
- With no grant: rf_RegWrite = 0, rf_WriteRegister = 0, rf_WriteData = 0.
- wait_cnt: increments (saturating at DBG_MAX_WAIT) on each IDLE cycle with dbg_req_valid && !dbg_req_ready. It clears on a debug grant or when dbg_req_valid = 0.

Debug read:
- Accepted at edge T (IDLE, we = 0): the address is latched and state goes to DBG_RD.
- In DBG_RD (cycle T+1), rf_rd_addr = latched addr. At the end of that cycle:
  - dbg_rsp_rdata <= 0 if addr == 0;
  - else core_wr_data if a core write to the same addr is granted that cycle (write bypass);
  - else rf_rd_data.
- dbg_rsp_valid <= 1, so the pulse appears in cycle T+2 and lasts one cycle. The state returns to IDLE.
- Read latency: 2 cycles from acceptance to response.
- rf_rd_addr = 0 outside DBG_RD.
- Debug write acceptance writes the register file in the same cycle, with no response pulse.

Test Plan:
- Reset with CLEAR_ON_RESET=1 → rf_RegWrite high for 31 cycles with addr 1..31 and data 0. Then init_done = 1 and core_wr_ready = 1 in the next cycle.
- In IDLE, core write x5 = 0xABCDE123 and a debug write x6 = 0x11 asserted in the same cycle → core granted (rf_WriteRegister = 5); debug granted the next cycle (rf_WriteRegister = 6, data 0x11).
- Debug read x5 after the above → dbg_rsp_valid pulses exactly 2 cycles after acceptance with rdata 0xABCDE123. Debug read x0 → rdata 0.
- Core valid held continuously with a debug write pending → after 8 blocked cycles, the 9th cycle has core_wr_ready = 0 and dbg_req_ready = 1. wait_cnt returns to 0.
- Core write x0 = 0xFFFFFFFF → core_wr_ready = 1 and rf_RegWrite = 0. Core write x7 = 0x42 during DBG_RD of x7 → response rdata 0x42.
- rst asserted at clear index 10, and again in DBG_RD → clear restarts at x1, init_done = 0, no dbg_rsp_valid pulse issued.
